fft_twiddle_w8_mult: RTL

- Pipelined complex multiplier by the radix-8 trivial twiddles W8^k, k = 0..3, for the 64-point FFT butterfly datapath.
- Sits between the butterfly adders and the next stage.
- Generalises the earlier combinational, real-only, fixed 16-bit 1/sqrt2 constant multiplier:
  - parametric data width and constant precision;
  - complex input with per-sample twiddle select;
  - round-to-nearest and saturation;
  - 3-stage pipeline with valid/ready flow control and a sideband tag.

---
 rtl/fft_twiddle_pkg.sv | 21 ++
 rtl/fft_twiddle_w8_mult_const_mult_csd.sv | 64 ++++++
 rtl/fft_twiddle_w8_mult.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fft_twiddle_pkg.sv
// Shared definitions for the radix-8 trivial-twiddle multiplier.
package fft_twiddle_pkg;

    localparam int TW_SEL_W = 2;

    // Twiddle select codes: W8^0, W8^1, W8^2 (= -j), W8^3.
    localparam logic [TW_SEL_W-1:0] TW_W0 = 2'd0;
    localparam logic [TW_SEL_W-1:0] TW_W1 = 2'd1;
    localparam logic [TW_SEL_W-1:0] TW_MJ = 2'd2;
    localparam logic [TW_SEL_W-1:0] TW_W3 = 2'd3;

    // 1/sqrt2 in unsigned fixed point: round(2^13 / sqrt2).
    localparam int          DEF_K_FRAC = 13;
    localparam int unsigned DEF_K_VAL  = 32'd5793;

    // Odd twiddles carry a 1/sqrt2 factor; even ones are a pure swap/negate.
    function automatic logic tw_needs_mult(input logic [TW_SEL_W-1:0] sel);
        return (sel == TW_W1) || (sel == TW_W3);
    endfunction

endpackage

// File: rtl/fft_twiddle_w8_mult_const_mult_csd.sv
// Signed x unsigned-constant multiplier built as a canonical-signed-digit
// shift-add tree. Purely combinational; the result is exact.
module const_mult_csd #(
    parameter int          IN_W  = 18,
    parameter int          K_W   = 13,
    parameter int unsigned K_VAL = 32'd5793
) (
    input  logic [IN_W-1:0]      x_i,
    output logic [IN_W+K_W:0]    p_o
);

    localparam int P_W = IN_W + K_W + 1;

    // Recode the constant into CSD digits: returns {neg_mask, pos_mask}.
    function automatic logic [2*(K_W+1)-1:0] csd_digits(input logic [K_W-1:0] k);
        logic [K_W+1:0] x;
        logic [K_W:0]   pos;
        logic [K_W:0]   neg;
        x   = {2'b00, k};
        pos = {(K_W+1){1'b0}};
        neg = {(K_W+1){1'b0}};
        for (int i = 0; i <= K_W; i++) begin
            if (x[0]) begin
                if (x[1]) begin
                    neg[i] = 1'b1;
                    x      = x + {{(K_W+1){1'b0}}, 1'b1};
                end else begin
                    pos[i] = 1'b1;
                    x      = x - {{(K_W+1){1'b0}}, 1'b1};
                end
            end else begin
                x = x;
            end
            x = x >> 1;
        end
        return {neg, pos};
    endfunction

    localparam logic [2*(K_W+1)-1:0] DIGITS = csd_digits(K_W'(K_VAL));
    localparam logic [K_W:0]         POS    = DIGITS[K_W:0];
    localparam logic [K_W:0]         NEG    = DIGITS[2*(K_W+1)-1:K_W+1];

    logic signed [P_W-1:0] x_ext_s;
    logic signed [P_W-1:0] acc_s;

    // Sum the shifted partial products; wrap-around in intermediates is
    // harmless because the final product always fits in P_W bits.
    always_comb begin
        x_ext_s = {{(P_W-IN_W){x_i[IN_W-1]}}, x_i};
        acc_s   = {P_W{1'b0}};
        for (int i = 0; i <= K_W; i++) begin
            if (POS[i]) begin
                acc_s = acc_s + (x_ext_s <<< i);
            end else if (NEG[i]) begin
                acc_s = acc_s - (x_ext_s <<< i);
            end else begin
                acc_s = acc_s;
            end
        end
    end

    assign p_o = acc_s;

endmodule

// File: rtl/fft_twiddle_w8_mult.sv
// Three-stage pipelined complex multiply by W8^k (k = 0..3) with
// round-half-up, saturation, valid/ready flow control and a sideband tag.
module fft_twiddle_w8_mult
    import fft_twiddle_pkg::*;
#(
    parameter int          DATA_W = 16,
    parameter int          K_FRAC = DEF_K_FRAC,
    parameter int unsigned K_VAL  = DEF_K_VAL,
    parameter int          TAG_W  = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_re,
    input  logic [DATA_W-1:0]   in_im,
    input  logic [TW_SEL_W-1:0] in_sel,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_re,
    output logic [DATA_W-1:0]   out_im,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_sat
);

    // One bit beyond DATA_W+1 keeps -(re+im) exact when both inputs are the
    // most negative value.
    localparam int S1_W = DATA_W + 2;
    localparam int P_W  = S1_W + K_FRAC + 1;
    localparam int R_W  = P_W - K_FRAC + 1;

    localparam logic [P_W:0] HALF =
        {{(P_W-K_FRAC+1){1'b0}}, 1'b1, {(K_FRAC-1){1'b0}}};
    localparam logic signed [R_W-1:0] R_MAX =
        {{(R_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [R_W-1:0] R_MIN =
        {{(R_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    if (K_VAL >= (32'd1 << K_FRAC)) begin : g_kval_check
        $error("K_VAL must be smaller than 2^K_FRAC");
    end

    // Round half up, drop K_FRAC fraction bits, clamp; returns {sat, value}.
    function automatic logic [DATA_W:0] round_sat(input logic [P_W-1:0] p);
        logic [P_W:0]          sum;
        logic signed [R_W-1:0] r;
        logic [DATA_W:0]       res;
        sum = {p[P_W-1], p} + HALF;
        r   = sum[P_W:K_FRAC];
        if (r > R_MAX) begin
            res = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        end else if (r < R_MIN) begin
            res = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            res = {1'b0, r[DATA_W-1:0]};
        end
        return res;
    endfunction

    logic                en_s;
    logic [S1_W-1:0]     re_x_s, im_x_s, a_d, b_d;
    logic [P_W-1:0]      pa_csd_s, pb_csd_s, pa_d, pb_d;
    logic [DATA_W:0]     rs_re_s, rs_im_s;

    logic                s1_valid_q, s2_valid_q, out_valid_q;
    logic [S1_W-1:0]     s1_a_q, s1_b_q;
    logic [TW_SEL_W-1:0] s1_sel_q;
    logic [TAG_W-1:0]    s1_tag_q, s2_tag_q, out_tag_q;
    logic [P_W-1:0]      s2_pa_q, s2_pb_q;
    logic [DATA_W-1:0]   out_re_q, out_im_q;
    logic                out_sat_q;

    assign en_s     = !out_valid_q || out_ready;
    assign in_ready = en_s;

    // Stage 1 pre-add/swap selected by the twiddle index.
    always_comb begin
        re_x_s = {{2{in_re[DATA_W-1]}}, in_re};
        im_x_s = {{2{in_im[DATA_W-1]}}, in_im};
        a_d    = re_x_s;
        b_d    = im_x_s;
        case (in_sel)
            TW_W0: begin a_d = re_x_s;          b_d = im_x_s;             end
            TW_W1: begin a_d = re_x_s + im_x_s; b_d = im_x_s - re_x_s;    end
            TW_MJ: begin a_d = im_x_s;          b_d = -re_x_s;            end
            TW_W3: begin a_d = im_x_s - re_x_s; b_d = -(re_x_s + im_x_s); end
            default: begin a_d = re_x_s;        b_d = im_x_s;             end
        endcase
    end

    const_mult_csd #(.IN_W(S1_W), .K_W(K_FRAC), .K_VAL(K_VAL)) u_mult_a (
        .x_i (s1_a_q),
        .p_o (pa_csd_s)
    );

    const_mult_csd #(.IN_W(S1_W), .K_W(K_FRAC), .K_VAL(K_VAL)) u_mult_b (
        .x_i (s1_b_q),
        .p_o (pb_csd_s)
    );

    // Stage 2 scaling: 1/sqrt2 for odd twiddles, plain alignment otherwise.
    always_comb begin
        if (tw_needs_mult(s1_sel_q)) begin
            pa_d = pa_csd_s;
            pb_d = pb_csd_s;
        end else begin
            pa_d = {s1_a_q[S1_W-1], s1_a_q, {K_FRAC{1'b0}}};
            pb_d = {s1_b_q[S1_W-1], s1_b_q, {K_FRAC{1'b0}}};
        end
    end

    assign rs_re_s = round_sat(s2_pa_q);
    assign rs_im_s = round_sat(s2_pb_q);

    // Pipeline registers: all stages advance together on en, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= {S1_W{1'b0}};
            s1_b_q      <= {S1_W{1'b0}};
            s1_sel_q    <= {TW_SEL_W{1'b0}};
            s1_tag_q    <= {TAG_W{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_pa_q     <= {P_W{1'b0}};
            s2_pb_q     <= {P_W{1'b0}};
            s2_tag_q    <= {TAG_W{1'b0}};
            out_valid_q <= 1'b0;
            out_re_q    <= {DATA_W{1'b0}};
            out_im_q    <= {DATA_W{1'b0}};
            out_tag_q   <= {TAG_W{1'b0}};
            out_sat_q   <= 1'b0;
        end else if (en_s) begin
            s1_valid_q  <= in_valid;
            s1_a_q      <= a_d;
            s1_b_q      <= b_d;
            s1_sel_q    <= in_sel;
            s1_tag_q    <= in_tag;
            s2_valid_q  <= s1_valid_q;
            s2_pa_q     <= pa_d;
            s2_pb_q     <= pb_d;
            s2_tag_q    <= s1_tag_q;
            out_valid_q <= s2_valid_q;
            out_re_q    <= rs_re_s[DATA_W-1:0];
            out_im_q    <= rs_im_s[DATA_W-1:0];
            out_tag_q   <= s2_tag_q;
            out_sat_q   <= rs_re_s[DATA_W] | rs_im_s[DATA_W];
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_tag   = out_tag_q;
    assign out_sat   = out_sat_q;

endmodule
